timer_ctrl: RTL and testbench

- Programmable timer controller that sequences the 16-bit up-counter (en/we/data/value/overflow interface) for the CPU.
- Provides a 4-register bus slave with a control/mode register, a reload register, a status register and a count readback.
- Generates the counter's load and count-enable strobes through a prescaler, runs one-shot or auto-reload modes, and raises an interrupt request on expiry.
- Sits between the CPU peripheral bus and one counter instance.

---
 rtl/timer_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_timer_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Timer controller: bus registers, prescaler and one-shot / auto-reload sequencing of a 16-bit up-counter.
// Define TIMER_CAPTURE_EN to add the cap_in capture register and CAPF status flag.
module timer_ctrl #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned PS_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       addr,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq,
  output logic             cnt_en,
  output logic             cnt_we,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_value,
`ifdef TIMER_CAPTURE_EN
  input  logic             cap_in,
`endif
  input  logic             cnt_overflow
);

  // Prescaler must reach 2^(2^PS_BITS-1)-1, so it needs 2^PS_BITS-1 bits.
  localparam int unsigned PSC_W = (32'd1 << PS_BITS) - 32'd1;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_RELOAD = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, EXPIRED} state_t;

  state_t             state, state_next;
  logic               ctrl_en, ctrl_en_next;
  logic               ctrl_ar, ctrl_ar_next;
  logic               ctrl_ie, ctrl_ie_next;
  logic [PS_BITS-1:0] ctrl_ps, ctrl_ps_next;
  logic [WIDTH-1:0]   reload, reload_next;
  logic               ovf, ovf_next;
  logic [PSC_W-1:0]   psc, psc_next;
  logic               cnt_en_next, cnt_we_next, irq_next;
  logic [WIDTH-1:0]   cnt_data_next;
  logic               ctrl_wr, reload_wr, status_wr, tick;
  logic               capf_cur, capf_next;
  logic [WIDTH-1:0]   value_rd;

  assign ctrl_wr   = wr && (addr == A_CTRL);
  assign reload_wr = wr && (addr == A_RELOAD);
  assign status_wr = wr && (addr == A_STATUS);

  function automatic logic [PSC_W-1:0] psc_limit(input logic [PS_BITS-1:0] ps);
    return ~({PSC_W{1'b1}} << ps);
  endfunction

`ifdef TIMER_CAPTURE_EN
  logic [2:0]       cap_sync;
  logic             cap_rise;
  logic             capf;
  logic [WIDTH-1:0] cap;

  assign cap_rise = cap_sync[1] & ~cap_sync[2];
  assign capf_cur = capf;
  assign value_rd = cap;

  always_comb begin
    capf_next = capf;
    if (status_wr && wdata[2]) capf_next = 1'b0;
    if (cap_rise)              capf_next = 1'b1;
  end

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_sync <= '0;
      cap      <= '0;
      capf     <= 1'b0;
    end else begin
      cap_sync <= {cap_sync[1:0], cap_in};
      capf     <= capf_next;
      if (cap_rise) cap <= cnt_value;
    end
  end
`else
  assign capf_cur  = 1'b0;
  assign capf_next = 1'b0;
  assign value_rd  = cnt_value;
`endif

  always_comb begin
    state_next   = state;
    ctrl_en_next = ctrl_en;
    ctrl_ar_next = ctrl_ar;
    ctrl_ie_next = ctrl_ie;
    ctrl_ps_next = ctrl_ps;
    reload_next  = reload;
    ovf_next     = ovf;
    psc_next     = psc;
    tick         = (psc == psc_limit(ctrl_ps));

    case (state)
      LOAD: begin
        state_next = RUN;
        psc_next   = '0;
      end
      RUN: begin
        psc_next = tick ? '0 : psc + PSC_W'(1);
        if (cnt_overflow) state_next = ctrl_ar ? LOAD : EXPIRED;
      end
      EXPIRED: begin
        ctrl_en_next = 1'b0;
        state_next   = IDLE;
      end
      default: ;
    endcase

    // Bus writes override the sequencing above.
    if (ctrl_wr) begin
      ctrl_en_next = wdata[0];
      ctrl_ar_next = wdata[1];
      ctrl_ie_next = wdata[2];
      ctrl_ps_next = wdata[4 +: PS_BITS];
      if (!wdata[0])                          state_next = IDLE;
      else if (state == IDLE || state == EXPIRED) state_next = LOAD;
      else if (state == RUN)                  psc_next   = '0;
    end
    if (reload_wr) reload_next = wdata;

    // A new overflow wins over a same-cycle clear.
    if (status_wr && wdata[0]) ovf_next = 1'b0;
    if (cnt_overflow)          ovf_next = 1'b1;

    cnt_we_next   = (state_next == LOAD);
    cnt_data_next = cnt_we_next ? reload_next : '0;
    cnt_en_next   = (state_next == RUN) && (psc_next == psc_limit(ctrl_ps_next));
    irq_next      = ctrl_ie_next & (ovf_next | capf_next);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ctrl_en  <= 1'b0;
      ctrl_ar  <= 1'b0;
      ctrl_ie  <= 1'b0;
      ctrl_ps  <= '0;
      reload   <= '0;
      ovf      <= 1'b0;
      psc      <= '0;
      cnt_en   <= 1'b0;
      cnt_we   <= 1'b0;
      cnt_data <= '0;
      irq      <= 1'b0;
    end else begin
      state    <= state_next;
      ctrl_en  <= ctrl_en_next;
      ctrl_ar  <= ctrl_ar_next;
      ctrl_ie  <= ctrl_ie_next;
      ctrl_ps  <= ctrl_ps_next;
      reload   <= reload_next;
      ovf      <= ovf_next;
      psc      <= psc_next;
      cnt_en   <= cnt_en_next;
      cnt_we   <= cnt_we_next;
      cnt_data <= cnt_data_next;
      irq      <= irq_next;
    end
  end

  // Register readback.
  always_comb begin
    rdata = '0;
    case (addr)
      A_CTRL: begin
        rdata[0]            = ctrl_en;
        rdata[1]            = ctrl_ar;
        rdata[2]            = ctrl_ie;
        rdata[4 +: PS_BITS] = ctrl_ps;
      end
      A_RELOAD: rdata = reload;
      A_STATUS: begin
        rdata[0] = ovf;
        rdata[1] = (state == LOAD) || (state == RUN);
        rdata[2] = capf_cur;
      end
      default: rdata = value_rd;
    endcase
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomised bench for timer_ctrl: a behavioural model of controller plus counter feeds the DUT and predicts every output.
module tb_timer_ctrl;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned PS_BITS = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_EXP = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       addr = '0;
  logic             wr = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic             irq, cnt_en, cnt_we;
  logic [WIDTH-1:0] cnt_data;
  logic [WIDTH-1:0] cnt_value = '0;
  logic             cnt_overflow = 1'b0;
`ifdef TIMER_CAPTURE_EN
  logic             cap_in = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.WIDTH(WIDTH), .PS_BITS(PS_BITS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .wdata(wdata), .rdata(rdata),
    .irq(irq), .cnt_en(cnt_en), .cnt_we(cnt_we), .cnt_data(cnt_data),
    .cnt_value(cnt_value),
`ifdef TIMER_CAPTURE_EN
    .cap_in(cap_in),
`endif
    .cnt_overflow(cnt_overflow)
  );

  // Reference model state, describing the cycle currently on the outputs.
  int         m_phase = P_IDLE;
  bit         m_en, m_ar, m_ie, m_ovf, m_capf;
  int         m_ps = 0;
  int         m_div = 0;
  bit [15:0]  m_reload, m_val, m_cap;
  bit [2:0]   m_sync;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit exp_en();
    int period;
    period = 1 << m_ps;
    return (m_phase == P_RUN) && ((m_div % period) == period - 1);
  endfunction

  function automatic bit [15:0] exp_rdata(input logic [1:0] a);
    bit [15:0] r;
    r = '0;
    case (a)
      2'd0: begin r[0] = m_en; r[1] = m_ar; r[2] = m_ie; r[7:4] = 4'(m_ps); end
      2'd1: r = m_reload;
      2'd2: begin
        r[0] = m_ovf;
        r[1] = (m_phase == P_LOAD) || (m_phase == P_RUN);
`ifdef TIMER_CAPTURE_EN
        r[2] = m_capf;
`endif
      end
      default: begin
`ifdef TIMER_CAPTURE_EN
        r = m_cap;
`else
        r = m_val;
`endif
      end
    endcase
    return r;
  endfunction

  // Advance model by one clock using the inputs sampled at that edge.
  task automatic model_step();
    bit ovfl, en_now, we_now, rise;
    bit [15:0] old_val;
    int old_phase;
    ovfl    = cnt_overflow;
    en_now  = exp_en();
    we_now  = (m_phase == P_LOAD);
    rise    = m_sync[1] & ~m_sync[2];
    old_val = m_val;
    if (we_now)      m_val = m_reload;
    else if (en_now) m_val = 16'(m_val + 16'd1);
    if (!rst) begin
      m_phase = P_IDLE; m_en = 0; m_ar = 0; m_ie = 0; m_ps = 0; m_div = 0;
      m_reload = '0; m_ovf = 0; m_capf = 0; m_cap = '0; m_sync = '0;
    end else begin
      old_phase = m_phase;
      if (old_phase == P_LOAD) begin
        m_phase = P_RUN; m_div = 0;
      end else if (old_phase == P_RUN) begin
        if (ovfl) m_phase = m_ar ? P_LOAD : P_EXP;
        else      m_div++;
      end else if (old_phase == P_EXP) begin
        m_en = 0; m_phase = P_IDLE;
      end
      if (wr && addr == 2'd0) begin
        m_en = wdata[0]; m_ar = wdata[1]; m_ie = wdata[2]; m_ps = int'(wdata[7:4]);
        if (!wdata[0]) m_phase = P_IDLE;
        else if (old_phase == P_IDLE || old_phase == P_EXP) m_phase = P_LOAD;
        else if (old_phase == P_RUN) m_div = 0;
      end
      if (wr && addr == 2'd1) m_reload = wdata;
      if (wr && addr == 2'd2 && wdata[0]) m_ovf = 0;
      if (ovfl) m_ovf = 1;
`ifdef TIMER_CAPTURE_EN
      if (wr && addr == 2'd2 && wdata[2]) m_capf = 0;
      if (rise) begin m_capf = 1; m_cap = old_val; end
      m_sync = {m_sync[1:0], cap_in};
`endif
    end
    cnt_value    = m_val;
    cnt_overflow = exp_en() && (m_val == 16'hFFFF);
  endtask

  task automatic tick(input bit chk);
    bit we;
    @(posedge clk);
    #1;
    model_step();
    @(negedge clk);
    if (chk) begin
      we = (m_phase == P_LOAD);
      check("cnt_en", WIDTH'(cnt_en), WIDTH'(exp_en()));
      check("cnt_we", WIDTH'(cnt_we), WIDTH'(we));
      check("cnt_data", cnt_data, we ? m_reload : 16'h0);
      check("irq", WIDTH'(irq), WIDTH'(m_ie & (m_ovf | m_capf)));
      check("rdata", rdata, exp_rdata(addr));
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [WIDTH-1:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick(1);
    wr = 1'b0;
  endtask

  task automatic wait_overflow(input string tag);
    int n;
    n = 0;
    while (!cnt_overflow && n < 60) begin tick(1); n++; end
    check(tag, WIDTH'(cnt_overflow), 16'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, last, gap_bad;
    int r;

    // Reset
    rst = 1'b0;
    tick(0);
    tick(1);
    rst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      check("reset_rdata", rdata, 16'h0);
    end
    check("reset_irq", WIDTH'(irq), 16'd0);
    check("reset_we", WIDTH'(cnt_we), 16'd0);

    // Auto-reload from 0xFFF0, PS=0: period (2^16 - 0xFFF0) + 1 = 17
    bus_write(2'd1, 16'hFFF0);
    bus_write(2'd0, 16'h0003);
    check("ar_first_we", WIDTH'(cnt_we), 16'd1);
    check("ar_first_data", cnt_data, 16'hFFF0);
    n = 0; last = 0; gap_bad = 0;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (cnt_we) begin
        if (i - last != 17) gap_bad++;
        last = i; n++;
      end
    end
    check("ar_reload_count", 16'(n), 16'd3);
    check("ar_period_errs", 16'(gap_bad), 16'd0);
    addr = 2'd2; #1;
    check("ar_ovf_set", WIDTH'(rdata[0]), 16'd1);

    // One-shot with irq
    bus_write(2'd0, 16'h0000);
    bus_write(2'd2, 16'h0001);
    bus_write(2'd1, 16'hFFFE);
    bus_write(2'd0, 16'h0005);
    n = 0;
    while (!irq && n < 20) begin tick(1); n++; end
    check("oneshot_irq_latency", 16'(n), 16'd3);
    tick(1);
    addr = 2'd0; #1;
    check("oneshot_en_cleared", WIDTH'(rdata[0]), 16'd0);
    for (int i = 0; i < 4; i++) tick(1);
    check("oneshot_idle_en", WIDTH'(cnt_en), 16'd0);
    bus_write(2'd2, 16'h0001);
    check("w1c_irq", WIDTH'(irq), 16'd0);

    // Prescale PS=2, then PS=0 mid-run
    bus_write(2'd1, 16'h0000);
    bus_write(2'd0, 16'h0021);
    n = 0;
    for (int i = 0; i < 40; i++) begin tick(1); if (cnt_en) n++; end
    check("ps2_en_count", 16'(n), 16'd10);
    bus_write(2'd0, 16'h0001);
    n = cnt_en ? 1 : 0;
    for (int i = 0; i < 7; i++) begin tick(1); if (cnt_en) n++; end
    check("ps0_every_clock", 16'(n), 16'd8);

    // Collisions with overflow
    bus_write(2'd0, 16'h0000);
    bus_write(2'd2, 16'h0001);
    bus_write(2'd1, 16'hFFF8);
    bus_write(2'd0, 16'h0003);
    wait_overflow("coll_ovf1_seen");
    bus_write(2'd2, 16'h0001);
    check("w1c_vs_ovf", WIDTH'(rdata[0]), 16'd1);
    wait_overflow("coll_ovf2_seen");
    bus_write(2'd0, 16'h0000);
    addr = 2'd2; #1;
    check("en0_vs_ovf_status", rdata, 16'h0001);
    tick(1);
    check("en0_vs_ovf_we", WIDTH'(cnt_we), 16'd0);

    // Reset mid-run with irq high
    bus_write(2'd2, 16'h0001);
    bus_write(2'd1, 16'hFFFE);
    bus_write(2'd0, 16'h0007);
    n = 0;
    while (!irq && n < 20) begin tick(1); n++; end
    check("rst_pre_irq", WIDTH'(irq), 16'd1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("rst_cnt_en", WIDTH'(cnt_en), 16'd0);
    check("rst_cnt_we", WIDTH'(cnt_we), 16'd0);
    check("rst_irq", WIDTH'(irq), 16'd0);
    for (int a = 0; a < 3; a++) begin
      addr = 2'(a); #1;
      check("rst_rdata", rdata, 16'h0);
    end

`ifdef TIMER_CAPTURE_EN
    bus_write(2'd1, 16'h1234);
    bus_write(2'd0, 16'h00F5);
    tick(1);
    cap_in = 1'b1;
    for (int i = 0; i < 3; i++) tick(1);
    addr = 2'd3; #1;
    check("cap_value", rdata, 16'h1234);
    addr = 2'd2; #1;
    check("capf", WIDTH'(rdata[2]), 16'd1);
    check("cap_irq", WIDTH'(irq), 16'd1);
    cap_in = 1'b0;
    tick(1);
`endif

    // Random traffic
    bus_write(2'd1, 16'hFFF0);
    bus_write(2'd0, 16'h0003);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      addr = 2'($urandom_range(0, 3));
      wdata = 16'($urandom);
      if (r < 6) begin
        addr = 2'd0; wr = 1'b1;
        wdata[7:4] = 4'($urandom_range(0, 2));
        wdata[0] = ($urandom_range(0, 7) != 0);
      end else if (r < 10) begin
        addr = 2'd1; wr = 1'b1;
        wdata = 16'hFFE0 | 16'($urandom_range(0, 31));
      end else if (r < 16) begin
        addr = 2'd2; wr = 1'b1;
      end else if (r < 17) begin
        addr = 2'd3; wr = 1'b1;
      end else if (r < 18) begin
        rst = 1'b0;
      end
`ifdef TIMER_CAPTURE_EN
      if ($urandom_range(0, 15) == 0) cap_in = ~cap_in;
`endif
      tick(1);
      wr = 1'b0;
      rst = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
